// File: rtl/sd_fifo_tx_filler.sv
// sd_fifo_tx_filler
// Wishbone read master feeding the SD transmit path. Fetches 32-bit words
// from system memory (base byte address adr, advancing by ADR_INC per word)
// using classic single transfers, one outstanding at a time, and stores
// them in a small FIFO that the SD data serialiser drains through a
// first-word-fall-through pop interface.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   en          transfer enable; low aborts, flushes FIFO, clears offset
//   adr         buffer base byte address
//   m_wb_*      Wishbone master (classic read cycles only)
//   rd          pop request from the SD transmitter
//   dat_o       FIFO head word (meaningful only when empty=0)
//   full/empty  registered FIFO status flags
module sd_fifo_tx_filler #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADR_INC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] adr,
    output logic [31:0] m_wb_adr_o,
    output logic        m_wb_we_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,
    input  logic        rd,
    output logic [31:0] dat_o,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   INC_C   = 32'(ADR_INC);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t        state, state_nxt;
    logic          cyc, cyc_nxt;
    logic [31:0]   offset, offset_nxt;
    logic          push, pop;
    logic [CW-1:0] count, count_nxt;
    logic [PW-1:0] wptr, rptr;
    logic [31:0]   mem [FIFO_DEPTH];

    // Bus outputs
    assign m_wb_adr_o = adr + offset;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_cti_o = 3'b000;
    assign m_wb_bte_o = 2'b00;
    assign m_wb_cyc_o = cyc;
    assign m_wb_stb_o = cyc;

    assign dat_o = mem[rptr];

    // Pops are suppressed while disabled; the flush takes priority anyway.
    assign pop = en && rd && !empty;

    // Next-state / request control
    always_comb begin
        state_nxt  = state;
        cyc_nxt    = cyc;
        offset_nxt = offset;
        push       = 1'b0;
        if (!en) begin
            // Abort: any ack arriving on this edge is dropped.
            state_nxt  = IDLE;
            cyc_nxt    = 1'b0;
            offset_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    // Space is checked at issue time; with only one transfer
                    // in flight the eventual ack always has a free entry.
                    if (count < DEPTH_C) begin
                        state_nxt = REQ;
                        cyc_nxt   = 1'b1;
                    end
                end
                REQ: begin
                    if (m_wb_ack_i) begin
                        push       = 1'b1;
                        offset_nxt = offset + INC_C;
                        state_nxt  = IDLE;
                        cyc_nxt    = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cyc_nxt   = 1'b0;
                end
            endcase
        end
    end

    // FIFO occupancy
    always_comb begin
        count_nxt = count;
        if (!en) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cyc    <= 1'b0;
            offset <= '0;
        end else begin
            state  <= state_nxt;
            cyc    <= cyc_nxt;
            offset <= offset_nxt;
        end
    end

    // Flags are registered from the next count so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
            if (!en) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + PW'(1);
                if (pop)  rptr <= rptr + PW'(1);
            end
        end
    end

    // Storage needs no reset; contents are only observed when non-empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= m_wb_dat_i;
    end

endmodule

// File: tb/tb_sd_fifo_tx_filler.sv
module tb_sd_fifo_tx_filler;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] adr;
    logic [31:0] m_wb_adr_o;
    logic        m_wb_we_o;
    logic [31:0] m_wb_dat_i;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_ack_i;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic        rd;
    logic [31:0] dat_o;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model controls
    int          ack_delay = 2;   // 1: ack in first stb cycle, 2: second
    logic        ack_en    = 1'b1;
    logic        force_en  = 1'b0;
    logic [31:0] force_val = '0;
    logic [31:0] data_base = '0;
    int          stb_cnt   = 0;

    sd_fifo_tx_filler #(.FIFO_DEPTH(8), .ADR_INC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adr        (adr),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_dat_i (m_wb_dat_i),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (m_wb_ack_i),
        .m_wb_cti_o (m_wb_cti_o),
        .m_wb_bte_o (m_wb_bte_o),
        .rd         (rd),
        .dat_o      (dat_o),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave: word at byte offset k*4 from the base reads data_base+k.
    initial begin
        m_wb_ack_i = 1'b0;
        m_wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (m_wb_stb_o === 1'b1) stb_cnt = stb_cnt + 1;
            else                     stb_cnt = 0;
            m_wb_ack_i = (m_wb_stb_o === 1'b1) && ack_en && (stb_cnt >= ack_delay);
            m_wb_dat_i = force_en ? force_val
                                  : data_base + ((m_wb_adr_o - adr) >> 2);
        end
    end

    typedef struct {
        logic [31:0] adr;
        logic [31:0] head;
        logic        full;
    } fetch_vec_t;

    fetch_vec_t fv [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for cyc to reach lvl; a timeout shows up as a failed check.
    task automatic wait_cyc(input logic lvl, input string name);
        int n;
        n = 0;
        while (m_wb_cyc_o !== lvl && n < 30) begin
            tick();
            n++;
        end
        chk(name, {31'b0, m_wb_cyc_o}, {31'b0, lvl});
    endtask

    initial begin
        int pops;
        fv[0] = '{32'h0000_1000, 32'hA0, 1'b0};
        fv[1] = '{32'h0000_1004, 32'hA0, 1'b0};
        fv[2] = '{32'h0000_1008, 32'hA0, 1'b0};
        fv[3] = '{32'h0000_100C, 32'hA0, 1'b0};
        fv[4] = '{32'h0000_1010, 32'hA0, 1'b0};
        fv[5] = '{32'h0000_1014, 32'hA0, 1'b0};
        fv[6] = '{32'h0000_1018, 32'hA0, 1'b0};
        fv[7] = '{32'h0000_101C, 32'hA0, 1'b1};

        // Reset state
        rst = 1'b0; en = 1'b0; rd = 1'b0; adr = 32'h1000;
        data_base = 32'hA0;
        #12;
        chk("rst_cyc",   {31'b0, m_wb_cyc_o}, 32'd0);
        chk("rst_stb",   {31'b0, m_wb_stb_o}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full",  {31'b0, full}, 32'd0);
        chk("rst_adr",   m_wb_adr_o, 32'h1000);
        chk("rst_const", {26'b0, m_wb_we_o, m_wb_cti_o, m_wb_bte_o}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Fill from 0x1000, ack on second request cycle, no pops
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(1'b1, "fill_req");
            chk("fill_adr", m_wb_adr_o, fv[i].adr);
            wait_cyc(1'b0, "fill_ack");
            chk("fill_head",  dat_o, fv[i].head);
            chk("fill_empty", {31'b0, empty}, 32'd0);
            chk("fill_full",  {31'b0, full}, {31'b0, fv[i].full});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_nocyc", {31'b0, m_wb_cyc_o}, 32'd0);
        end

        // Single pop from full, then refill from 0x1020
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("pop_head", dat_o, 32'hA1);
        chk("pop_full", {31'b0, full}, 32'd0);
        wait_cyc(1'b1, "refill_req");
        chk("refill_adr", m_wb_adr_o, 32'h1020);
        wait_cyc(1'b0, "refill_ack");
        chk("refill_full", {31'b0, full}, 32'd1);

        // Continuous pop, same-cycle ack: popped stream must be A1, A2, ...
        ack_delay = 1;
        rd = 1'b1;
        pops = 0;
        for (int n = 0; n < 100 && pops < 20; n++) begin
            if (empty === 1'b0) begin
                chk("pop_seq", dat_o, 32'hA1 + 32'(pops));
                pops++;
            end
            tick();
        end
        chk("pop_count", 32'(pops), 32'd20);
        rd = 1'b0;
        en = 1'b0;
        tick();
        chk("flush_empty", {31'b0, empty}, 32'd1);
        chk("flush_full",  {31'b0, full}, 32'd0);
        chk("flush_cyc",   {31'b0, m_wb_cyc_o}, 32'd0);
        chk("flush_adr",   m_wb_adr_o, 32'h1000);

        // Pop on empty is ignored; next word arrives intact
        adr = 32'h2000;
        ack_delay = 2;
        ack_en = 1'b0;
        en = 1'b1;
        rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("uflow_empty", {31'b0, empty}, 32'd1);
        end
        chk("uflow_adr", m_wb_adr_o, 32'h2000);
        rd = 1'b0;
        force_en = 1'b1;
        force_val = 32'h55AA55AA;
        ack_en = 1'b1;
        wait_cyc(1'b0, "uflow_ack");
        chk("uflow_data",  dat_o, 32'h55AA55AA);
        chk("uflow_empty2", {31'b0, empty}, 32'd0);
        en = 1'b0;
        force_en = 1'b0;
        tick();

        // Abort with an ack on the same edge: word is discarded
        data_base = 32'hB0;
        en = 1'b1;
        wait_cyc(1'b1, "abort_req");
        tick();
        force_en = 1'b1;
        force_val = 32'hDEADBEEF;
        en = 1'b0;
        tick();
        chk("abort_cyc",   {31'b0, m_wb_cyc_o}, 32'd0);
        chk("abort_empty", {31'b0, empty}, 32'd1);
        chk("abort_full",  {31'b0, full}, 32'd0);
        chk("abort_adr",   m_wb_adr_o, 32'h2000);
        force_en = 1'b0;
        en = 1'b1;
        wait_cyc(1'b1, "reen_req");
        chk("reen_adr", m_wb_adr_o, 32'h2000);
        wait_cyc(1'b0, "reen_ack");
        chk("reen_data", dat_o, 32'hB0);
        en = 1'b0;
        tick();

        // Asynchronous reset mid-request with three words buffered
        adr = 32'h3000;
        data_base = 32'hC0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1'b1, "pre_rst_req");
            wait_cyc(1'b0, "pre_rst_ack");
        end
        chk("pre_rst_head", dat_o, 32'hC0);
        wait_cyc(1'b1, "pre_rst_req4");
        chk("pre_rst_adr", m_wb_adr_o, 32'h300C);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cyc",   {31'b0, m_wb_cyc_o}, 32'd0);
        chk("arst_stb",   {31'b0, m_wb_stb_o}, 32'd0);
        chk("arst_empty", {31'b0, empty}, 32'd1);
        chk("arst_full",  {31'b0, full}, 32'd0);
        chk("arst_adr",   m_wb_adr_o, 32'h3000);
        tick();
        chk("arst_hold", {31'b0, m_wb_cyc_o}, 32'd0);
        rst = 1'b1;
        wait_cyc(1'b1, "post_rst_req");
        chk("post_rst_adr", m_wb_adr_o, 32'h3000);
        wait_cyc(1'b0, "post_rst_ack");
        chk("post_rst_data", dat_o, 32'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
